// File: rtl/cpu_mem_stall_pkg.sv
// cpu_pkg: shared definitions for the cpu_mem_stall core.
//   - opcode values
//   - instruction field positions
//   - FSM state encoding
//   - ALU select enum
//   - memory-opcode helper
package cpu_pkg;

   localparam logic [7:0] OP_LOADI = 8'd0;
   localparam logic [7:0] OP_MOV   = 8'd1;
   localparam logic [7:0] OP_ADD   = 8'd2;
   localparam logic [7:0] OP_SUB   = 8'd3;
   localparam logic [7:0] OP_AND   = 8'd4;
   localparam logic [7:0] OP_OR    = 8'd5;
   localparam logic [7:0] OP_J     = 8'd6;
   localparam logic [7:0] OP_BEQ   = 8'd7;
   localparam logic [7:0] OP_BNE   = 8'd8;
   localparam logic [7:0] OP_LWD   = 8'd9;
   localparam logic [7:0] OP_LWI   = 8'd10;
   localparam logic [7:0] OP_SWD   = 8'd11;
   localparam logic [7:0] OP_SWI   = 8'd12;

   localparam int FIELD_W  = 8;
   localparam int OP_LSB   = 24;
   localparam int DEST_LSB = 16;
   localparam int SRC1_LSB = 8;
   localparam int IMM_LSB  = 0;

   typedef enum logic {
      ST_EXEC = 1'b0,
      ST_MEM  = 1'b1
   } state_t;

   typedef enum logic [2:0] {
      ALU_PASS_IMM = 3'd0,
      ALU_PASS_R1  = 3'd1,
      ALU_ADD      = 3'd2,
      ALU_SUB      = 3'd3,
      ALU_AND      = 3'd4,
      ALU_OR       = 3'd5
   } alu_sel_t;

   function automatic logic is_mem_op(input logic [7:0] op);
      return (op == OP_LWD) || (op == OP_LWI) || (op == OP_SWD) || (op == OP_SWI);
   endfunction

endpackage

// File: rtl/cpu_mem_stall_if.sv
// Data-memory bus between the core (master) and a data memory / cache (slave).
//   READ, WRITE     : access requests, held for the whole access
//   ADDRESS         : access address
//   WRITEDATA       : store data
//   READDATA        : load data, sampled at the edge where BUSYWAIT is low
//   BUSYWAIT        : memory busy, stalls the core while high
interface cpu_mem_stall_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  READ;
   logic                  WRITE;
   logic [DATA_WIDTH-1:0] ADDRESS;
   logic [DATA_WIDTH-1:0] WRITEDATA;
   logic [DATA_WIDTH-1:0] READDATA;
   logic                  BUSYWAIT;

   modport master (
      output READ, WRITE, ADDRESS, WRITEDATA,
      input  READDATA, BUSYWAIT
   );

   modport slave (
      input  READ, WRITE, ADDRESS, WRITEDATA,
      output READDATA, BUSYWAIT
   );
endinterface

// File: rtl/cpu_mem_stall_reg_file_p.sv
// reg_file_p: general register file, 2 asynchronous read ports, 1 synchronous
// write port, async active-low reset clearing every register.
//   clk, rst_n      : clock / reset
//   ra1, ra2        : read addresses, rd_data1 / rd_data2 combinational
//   we, wa, wd      : write enable, address, data (written on rising edge)
// A read of the register being written in the same cycle returns the old value.
module reg_file_p #(
   parameter int DATA_WIDTH = 8,
   parameter int REG_COUNT  = 8,
   localparam int IDX_W     = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [IDX_W-1:0]      ra1,
   input  logic [IDX_W-1:0]      ra2,
   output logic [DATA_WIDTH-1:0] rd_data1,
   output logic [DATA_WIDTH-1:0] rd_data2,
   input  logic                  we,
   input  logic [IDX_W-1:0]      wa,
   input  logic [DATA_WIDTH-1:0] wd
);

   logic [DATA_WIDTH-1:0] regs [REG_COUNT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[wa] <= wd;
      end
   end

   assign rd_data1 = regs[ra1];
   assign rd_data2 = regs[ra2];

endmodule

// File: rtl/cpu_mem_stall.sv
// cpu_mem_stall: single-issue core with load/store over a BUSYWAIT data bus.
//   CLK, RESET_N  : clock, async active-low reset
//   INSTRUCTION   : instruction fetched at PC
//   PC            : program counter
//   RETIRED       : committed-instruction counter (wraps)
//   ILLEGAL       : one-cycle pulse after an unknown opcode commits
//   dmem          : data-memory bus (master side)
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_EXEC | decode/execute; non-memory ops commit at the next edge
// ST_MEM  | memory access in flight; commits at first edge with BUSYWAIT low
module cpu_mem_stall
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int REG_COUNT  = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic [31:0]          INSTRUCTION,
   output logic [31:0]          PC,
   output logic [CNT_WIDTH-1:0] RETIRED,
   output logic                 ILLEGAL,
   cpu_mem_stall_if.master      dmem
);

   localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

   state_t                state;
   logic [IDX_W-1:0]      rd_q;

   logic [7:0]            opcode;
   logic [7:0]            offset;
   logic [IDX_W-1:0]      rd_idx;
   logic [IDX_W-1:0]      rs1_idx;
   logic [IDX_W-1:0]      rs2_idx;
   logic [DATA_WIDTH-1:0] imm_sext;
   logic [DATA_WIDTH-1:0] rs1_data;
   logic [DATA_WIDTH-1:0] rs2_data;
   logic [DATA_WIDTH-1:0] alu_result;
   logic [DATA_WIDTH-1:0] mem_addr;
   logic [31:0]           pc_plus4;
   logic [31:0]           br_target;
   alu_sel_t              alu_sel;
   logic                  wr_exec;
   logic                  is_mem;
   logic                  is_load;
   logic                  illegal_op;
   logic                  taken;
   logic                  rf_we;
   logic [IDX_W-1:0]      rf_wa;
   logic [DATA_WIDTH-1:0] rf_wd;

   // Only the low index bits of SRC1 address a register; the rest are don't-care.
   logic                  unused_src1_bits;
   assign unused_src1_bits = ^INSTRUCTION[SRC1_LSB +: FIELD_W];

   assign opcode   = INSTRUCTION[OP_LSB +: FIELD_W];
   assign offset   = INSTRUCTION[DEST_LSB +: FIELD_W];
   assign rd_idx   = INSTRUCTION[DEST_LSB +: IDX_W];
   assign rs1_idx  = INSTRUCTION[SRC1_LSB +: IDX_W];
   assign rs2_idx  = INSTRUCTION[IMM_LSB +: IDX_W];
   assign imm_sext = DATA_WIDTH'($signed(INSTRUCTION[IMM_LSB +: FIELD_W]));

   assign pc_plus4  = PC + 32'd4;
   assign br_target = pc_plus4 + (32'($signed(offset)) << 2);

   always_comb begin
      alu_sel    = ALU_PASS_IMM;
      wr_exec    = 1'b0;
      is_load    = 1'b0;
      illegal_op = 1'b0;
      taken      = 1'b0;
      mem_addr   = rs2_data;
      is_mem     = is_mem_op(opcode);
      case (opcode)
         OP_LOADI: begin wr_exec = 1'b1; alu_sel = ALU_PASS_IMM; end
         OP_MOV:   begin wr_exec = 1'b1; alu_sel = ALU_PASS_R1;  end
         OP_ADD:   begin wr_exec = 1'b1; alu_sel = ALU_ADD;      end
         OP_SUB:   begin wr_exec = 1'b1; alu_sel = ALU_SUB;      end
         OP_AND:   begin wr_exec = 1'b1; alu_sel = ALU_AND;      end
         OP_OR:    begin wr_exec = 1'b1; alu_sel = ALU_OR;       end
         OP_J:     taken = 1'b1;
         OP_BEQ:   taken = (rs1_data == rs2_data);
         OP_BNE:   taken = (rs1_data != rs2_data);
         OP_LWD:   is_load = 1'b1;
         OP_LWI:   begin is_load = 1'b1; mem_addr = imm_sext; end
         OP_SWD:   ;
         OP_SWI:   mem_addr = imm_sext;
         default:  illegal_op = 1'b1;
      endcase
   end

   always_comb begin
      case (alu_sel)
         ALU_PASS_IMM: alu_result = imm_sext;
         ALU_PASS_R1:  alu_result = rs1_data;
         ALU_ADD:      alu_result = rs1_data + rs2_data;
         ALU_SUB:      alu_result = rs1_data + ~rs2_data + DATA_WIDTH'(1);
         ALU_AND:      alu_result = rs1_data & rs2_data;
         ALU_OR:       alu_result = rs1_data | rs2_data;
         default:      alu_result = '0;
      endcase
   end

   // In ST_MEM the READ register doubles as the "this is a load" flag.
   always_comb begin
      if (state == ST_MEM) begin
         rf_we = dmem.READ && !dmem.BUSYWAIT;
         rf_wa = rd_q;
         rf_wd = dmem.READDATA;
      end else begin
         rf_we = wr_exec;
         rf_wa = rd_idx;
         rf_wd = alu_result;
      end
   end

   reg_file_p #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_COUNT  (REG_COUNT)
   ) u_rf (
      .clk      (CLK),
      .rst_n    (RESET_N),
      .ra1      (rs1_idx),
      .ra2      (rs2_idx),
      .rd_data1 (rs1_data),
      .rd_data2 (rs2_data),
      .we       (rf_we),
      .wa       (rf_wa),
      .wd       (rf_wd)
   );

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state          <= ST_EXEC;
         PC             <= '0;
         RETIRED        <= '0;
         ILLEGAL        <= 1'b0;
         rd_q           <= '0;
         dmem.READ      <= 1'b0;
         dmem.WRITE     <= 1'b0;
         dmem.ADDRESS   <= '0;
         dmem.WRITEDATA <= '0;
      end else begin
         ILLEGAL <= 1'b0;
         case (state)
            ST_EXEC: begin
               if (is_mem) begin
                  state          <= ST_MEM;
                  dmem.READ      <= is_load;
                  dmem.WRITE     <= !is_load;
                  dmem.ADDRESS   <= mem_addr;
                  dmem.WRITEDATA <= rs1_data;
                  rd_q           <= rd_idx;
               end else begin
                  PC      <= taken ? br_target : pc_plus4;
                  RETIRED <= RETIRED + CNT_WIDTH'(1);
                  ILLEGAL <= illegal_op;
               end
            end
            ST_MEM: begin
               if (!dmem.BUSYWAIT) begin
                  state      <= ST_EXEC;
                  dmem.READ  <= 1'b0;
                  dmem.WRITE <= 1'b0;
                  PC         <= pc_plus4;
                  RETIRED    <= RETIRED + CNT_WIDTH'(1);
               end
            end
            default: state <= ST_EXEC;
         endcase
      end
   end

endmodule

// File: doc/cpu_mem_stall.md
Name: cpu_mem_stall

Overview:
- Next-generation single-issue CPU core with a parametrised datapath width and register count.
- Adds load/store instructions with a BUSYWAIT handshake to an external data memory. The core stalls PC and writeback while memory is busy.
- Adds a retired-instruction counter and an illegal-opcode flag.
- Sits between instruction memory (INSTRUCTION driven from PC) and data memory / cache.

Parameters:
- DATA_WIDTH, 8: register, ALU, data-memory address and data width (8..32).
- REG_COUNT, 8: number of general registers (power of two, 2..256).
- CNT_WIDTH, 16: width of the RETIRED counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- INSTRUCTION  in  32  instruction at PC.
- PC  out  32  current program counter.
- READ  out  1  data-memory read request.
- WRITE  out  1  data-memory write request.
- ADDRESS  out  DATA_WIDTH  data-memory address.
- WRITEDATA  out  DATA_WIDTH  store data.
- READDATA  in  DATA_WIDTH  load data.
- BUSYWAIT  in  1  memory busy; high stalls the core.
- RETIRED  out  CNT_WIDTH  count of committed instructions.
- ILLEGAL  out  1  one-cycle pulse when an unknown opcode commits.

Behaviour:
- Instruction fields:
  - OPCODE = [31:24]
  - DEST/OFFSET = [23:16]
  - SRC1 = [15:8]
  - SRC2/IMM = [7:0]
  - Register indices use the low log2(REG_COUNT) bits.
- IMM is sign-extended to DATA_WIDTH.
- Opcodes:
  - 0 loadi, 1 mov, 2 add, 3 sub, 4 and, 5 or
  - 6 j, 7 beq, 8 bne
  - 9 lwd (rd = mem[r2]), 10 lwi (rd = mem[imm])
  - 11 swd (mem[r2] = r1), 12 swi (mem[imm] = r1)
  - For stores, the data register is SRC1.
- Unknown opcode: commits as NOP and pulses ILLEGAL.
- Arithmetic is modulo 2^DATA_WIDTH; sub = r1 + ~r2 + 1.
- Branch target = PC + 4 + (sext(OFFSET) << 2), modulo 2^32.
  - beq is taken when r1 == r2; bne when r1 != r2; j is always taken.
- Reset (async, RESET_N low):
  - PC = 0, all registers = 0, state = EXEC.
  - READ = WRITE = 0, ADDRESS = WRITEDATA = 0.
  - RETIRED = 0, ILLEGAL = 0.
  - Reset mid-MEM aborts the access with no writeback.
- FSM states: EXEC, MEM.
  - EXEC, non-memory opcode: commits at the next edge (1 cycle). Register write if applicable, PC = target or PC + 4, RETIRED += 1.
  - EXEC, memory opcode: no commit; next state MEM. ADDRESS and WRITEDATA are latched at that edge.
  - MEM: READ (loads) or WRITE (stores) held high. ADDRESS and WRITEDATA stay stable.
  - MEM exit: at the first edge with BUSYWAIT == 0 the instruction commits. Load writes READDATA into rd. PC += 4, RETIRED += 1, next state EXEC.
  - A zero-wait memory gives 2 cycles per memory instruction.
  - A memory that needs wait states must raise BUSYWAIT combinationally in the first MEM cycle.
- BUSYWAIT is ignored in EXEC.
- BUSYWAIT held high indefinitely: the core stays in MEM; PC and registers are frozen.
- READ and WRITE are never high together, and are low in EXEC.
- RETIRED wraps from all-ones to 0.
- ILLEGAL is a registered pulse, high for the cycle after the illegal commit.
- A write to any register, including index 0, is legal (no hardwired zero).
- Same-cycle read and write of one register returns the old value.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams
  - field bit positions
  - FSM state encoding
  - the ALU select enum
- One natural sub-module, reg_file_p: parametrised register file with 2 read ports and 1 write port, async reset.
- ALU, branch logic and FSM stay inline.

Test Plan:
1. Reset: hold RESET_N low, then release → PC = 0, RETIRED = 0, READ = WRITE = 0. Asserting RESET_N low mid-program returns PC to 0 asynchronously.
2. ALU and wrap: loadi r1,0x7F; loadi r2,0x02; add r3,r1,r2; sub r4,r2,r1 (DATA_WIDTH = 8) → r3 = 0x81, r4 = 0x83; PC = 16; RETIRED = 4.
3. Branches: with r1 == r2, beq offset 0xFE at PC 8 → PC = 4. bne with the same registers → PC = 12. j offset 0x01 at PC 0 → PC = 8.
4. Load/store, zero wait: swi r1 to 0x10, then lwi r5 from 0x10 with a model memory, BUSYWAIT = 0 → each instruction takes 2 cycles, WRITE then READ pulses one cycle each, r5 = r1.
5. Stall: lwd with BUSYWAIT high for 5 cycles, READDATA = 0xA5 at release → PC constant for 6 cycles, r_d = 0xA5 after commit, RETIRED increments once.
6. Illegal and counter: opcode 0xFF → ILLEGAL high for 1 cycle, registers unchanged, PC += 4. Preload RETIRED near max (CNT_WIDTH = 4), retire 16 instructions → RETIRED wraps to its start value.
